// File: rtl/jtpopeye_objsched_pkg.sv
// Shared constants and types for the TPP2 object-scan path: RAM geometry,
// object entry field positions and the scheduler state encoding.
package jtpopeye_objsched_pkg;

    localparam int OBJ_AW = 7;
    localparam int OBJ_DW = 29;

    // Field positions inside a 29-bit object entry
    localparam int Y_MSB     = 15;
    localparam int Y_LSB     = 8;
    localparam int X_MSB     = 7;
    localparam int X_LSB     = 0;
    localparam int ID_HI     = 28;
    localparam int ID_LO_MSB = 22;
    localparam int ID_LO_LSB = 16;
    localparam int PAL_MSB   = 26;
    localparam int PAL_LSB   = 24;
    localparam int HFLIP     = 23;
    localparam int VFLIP     = 27;

    typedef logic [OBJ_DW-1:0] obj_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DMA_ISSUE,
        ST_DMA_DONE
    } sched_st_e;

    function automatic logic [7:0] obj_y(input obj_t e);
        return e[Y_MSB:Y_LSB];
    endfunction

    function automatic logic [7:0] obj_x(input obj_t e);
        return e[X_MSB:X_LSB];
    endfunction

    function automatic logic [7:0] obj_id(input obj_t e);
        return {e[ID_HI], e[ID_LO_MSB:ID_LO_LSB]};
    endfunction

endpackage

// File: rtl/jtpopeye_objsched_if.sv
// DMA access port into object RAM; the requester holds dma_req until dma_ack.
interface jtpopeye_objsched_if;
    import jtpopeye_objsched_pkg::*;

    logic              dma_req;
    logic              dma_we;
    logic [OBJ_AW-1:0] dma_addr;
    logic [OBJ_DW-1:0] dma_din;
    logic              dma_ack;
    logic [OBJ_DW-1:0] dma_dout;

    modport master (
        output dma_req, dma_we, dma_addr, dma_din,
        input  dma_ack, dma_dout
    );

    modport slave (
        input  dma_req, dma_we, dma_addr, dma_din,
        output dma_ack, dma_dout
    );

endinterface

// File: rtl/jtpopeye_objzone.sv
// Combinational in-zone test: an object is on this line when (Y+V) mod 256 < 8.
module jtpopeye_objzone
    import jtpopeye_objsched_pkg::*;
(
    input  logic [7:0] obj_y,
    input  logic [7:0] vpos,
    output logic       in_zone
);

    logic [7:0] sum;

    always_comb begin
        sum     = obj_y + vpos;
        in_zone = (sum[7:3] == 5'd0);
    end

endmodule

// File: rtl/jtpopeye_objsched.sv
// Per-line object RAM walker feeding the line buffer, with DMA arbitration
// of object RAM while no scan is running.
module jtpopeye_objsched
    import jtpopeye_objsched_pkg::*;
#(
    parameter int OBJ_N  = 96,
    parameter int MAX_WR = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pxl_cen,
    input  logic [7:0]        H,
    input  logic [7:0]        V,
    input  logic              LVBL,
    output logic [OBJ_AW-1:0] obj_addr,
    output logic              obj_we,
    output logic [OBJ_DW-1:0] obj_din,
    input  logic [OBJ_DW-1:0] obj_dout,
    output logic [OBJ_DW-1:0] DO,
    output logic              ROHVS,
    jtpopeye_objsched_if.slave dma,
    output logic              obj_ovf
);

    localparam int                WC_W   = $clog2(MAX_WR + 1);
    localparam logic [OBJ_AW-1:0] LAST_K = OBJ_AW'(OBJ_N - 1);
    localparam logic [WC_W-1:0]   WC_MAX = WC_W'(MAX_WR);

    sched_st_e         st_q, st_d;
    logic [OBJ_AW-1:0] k_q, k_d;
    logic              last_q, last_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic              pend_q, pend_d;
    logic [OBJ_AW-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [OBJ_DW-1:0] din_q, din_d;
    logic [OBJ_DW-1:0] do_q, do_d;
    logic              rohvs_q, rohvs_d;
    logic              ack_q, ack_d;
    logic [OBJ_DW-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d;

    logic line_start;
    logic in_zone;

    jtpopeye_objzone u_zone (
        .obj_y   (obj_dout[Y_MSB:Y_LSB]),
        .vpos    (V),
        .in_zone (in_zone)
    );

    assign line_start = LVBL && (H == 8'd0);

    always_comb begin
        st_d    = st_q;
        k_d     = k_q;
        last_d  = last_q;
        wc_d    = wc_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        din_d   = din_q;
        do_d    = do_q;
        rohvs_d = rohvs_q;
        ack_d   = 1'b0;
        dout_d  = dout_q;
        ovf_d   = ovf_q;

        case (st_q)
            ST_IDLE: begin
                // A deferred start waits for an even H so the odd/even
                // address/latch phases line up from the first object.
                if (LVBL && !H[0] && (H == 8'd0 || pend_q)) begin
                    st_d   = ST_SCAN;
                    k_d    = '0;
                    last_d = 1'b0;
                    wc_d   = '0;
                    ovf_d  = 1'b0;
                    pend_d = 1'b0;
                end else if (pend_q) begin
                    pend_d = LVBL;
                end else if (dma.dma_req) begin
                    st_d   = ST_DMA_ISSUE;
                    addr_d = dma.dma_addr;
                    we_d   = dma.dma_we;
                    din_d  = dma.dma_din;
                end
            end

            ST_SCAN: begin
                rohvs_d = 1'b1;
                if (!LVBL) begin
                    st_d = ST_IDLE;
                end else if (H[0]) begin
                    if (last_q) st_d = ST_IDLE;
                    else        addr_d = k_q;
                end else begin
                    do_d = obj_dout;
                    if (in_zone) begin
                        if (wc_q < WC_MAX) begin
                            rohvs_d = 1'b0;
                            wc_d    = wc_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (k_q == LAST_K) last_d = 1'b1;
                    else               k_d    = k_q + 1'b1;
                end
            end

            ST_DMA_ISSUE: begin
                st_d   = ST_DMA_DONE;
                ack_d  = 1'b1;
                dout_d = obj_dout;
                if (line_start) pend_d = 1'b1;
            end

            ST_DMA_DONE: begin
                st_d = ST_IDLE;
                if (line_start) pend_d = 1'b1;
            end

            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            k_q     <= '0;
            last_q  <= 1'b0;
            wc_q    <= '0;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            do_q    <= '0;
            rohvs_q <= 1'b1;
            ack_q   <= 1'b0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (pxl_cen) begin
            st_q    <= st_d;
            k_q     <= k_d;
            last_q  <= last_d;
            wc_q    <= wc_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
            do_q    <= do_d;
            rohvs_q <= rohvs_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign obj_addr     = addr_q;
    assign obj_we       = we_q;
    assign obj_din      = din_q;
    assign DO           = do_q;
    assign ROHVS        = rohvs_q;
    assign obj_ovf      = ovf_q;
    assign dma.dma_ack  = ack_q;
    assign dma.dma_dout = dout_q;

endmodule

// File: tb/tb_jtpopeye_objsched.sv
// Randomized bench for the object scheduler against a per-line reference model
// built from the zone/budget rules and a shadow copy of object RAM.
module tb_jtpopeye_objsched;

    localparam int OBJ_N  = 96;
    localparam int MAX_WR = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pxl_cen;
    logic [7:0]  H, V;
    logic        LVBL;
    logic [6:0]  obj_addr;
    logic        obj_we;
    logic [28:0] obj_din;
    logic [28:0] obj_dout;
    logic [28:0] DO;
    logic        ROHVS;
    logic        obj_ovf;

    jtpopeye_objsched_if dma_if ();

    jtpopeye_objsched #(.OBJ_N(OBJ_N), .MAX_WR(MAX_WR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .H        (H),
        .V        (V),
        .LVBL     (LVBL),
        .obj_addr (obj_addr),
        .obj_we   (obj_we),
        .obj_din  (obj_din),
        .obj_dout (obj_dout),
        .DO       (DO),
        .ROHVS    (ROHVS),
        .dma      (dma_if.slave),
        .obj_ovf  (obj_ovf)
    );

    always #5 clk = ~clk;

    // Object RAM: asynchronous read, write on pxl_cen; bench-side load port
    logic [28:0] mem [0:127];
    logic        tb_we;
    logic [6:0]  tb_a;
    logic [28:0] tb_d;
    assign obj_dout = mem[obj_addr];
    always @(posedge clk) begin
        if (tb_we)                mem[tb_a]     <= tb_d;
        else if (pxl_cen && obj_we) mem[obj_addr] <= obj_din;
    end

    logic [28:0] ref_mem [0:127];
    logic [28:0] cur_do;
    logic        cur_ovf;
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        pxl_cen = 1'b1;
        @(posedge clk); #1;
        pxl_cen = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic load_mem();
        for (int a = 0; a < 128; a++) begin
            @(negedge clk);
            tb_we = 1'b1; tb_a = 7'(a); tb_d = ref_mem[a];
        end
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // pct percent of entries forced into the zone for the current V
    task automatic fill_rand(input int pct);
        for (int j = 0; j < 128; j++) begin
            ref_mem[j] = 29'($urandom);
            if (int'($urandom_range(99, 0)) < pct)
                ref_mem[j][15:8] = 8'(256 - int'(V) + int'($urandom_range(7, 0)));
        end
    endtask

    task automatic dma_xfer(input logic we, input logic [6:0] a, input logic [28:0] d);
        dma_if.dma_req = 1'b1; dma_if.dma_we = we; dma_if.dma_addr = a; dma_if.dma_din = d;
        step();
        chk("dma_ack_issue", dma_if.dma_ack, 0);
        chk("obj_we_issue", obj_we, we);
        chk("obj_addr_issue", obj_addr, a);
        if (we) chk("obj_din_issue", obj_din, d);
        step();
        chk("dma_ack_done", dma_if.dma_ack, 1);
        chk("obj_we_done", obj_we, 0);
        if (!we) chk("dma_dout", dma_if.dma_dout, ref_mem[a]);
        dma_if.dma_req = 1'b0;
        if (we) ref_mem[a] = d;
        step();
        chk("dma_ack_drop", dma_if.dma_ack, 0);
    endtask

    // One line: s = start delay in pxl_cen, abort_h = H where LVBL falls (256: never)
    task automatic run_line(input int s, input int abort_h);
        bit         low_at [256];
        int         ovf_k, wc, nlow_exp, nlow_got, k;
        logic [7:0] sum;
        for (int i = 0; i < 256; i++) low_at[i] = 1'b0;
        ovf_k = -1; wc = 0; nlow_exp = 0; nlow_got = 0;
        for (int j = 0; j < OBJ_N; j++) begin
            sum = ref_mem[j][15:8] + V;
            if (sum < 8'd8) begin
                if (wc < MAX_WR) begin
                    low_at[2*j+2+s] = 1'b1;
                    wc++;
                    if (2*j+2+s < abort_h) nlow_exp++;
                end else if (ovf_k < 0) begin
                    ovf_k = j;
                end
            end
        end
        for (int h = 0; h <= 2*OBJ_N+3+s; h++) begin
            H = 8'(h);
            LVBL = (h < abort_h);
            if (h > 0) dma_if.dma_req = 1'b0;
            step();
            if (h < abort_h) begin
                if (h == s) cur_ovf = 1'b0;
                k = (h - 2 - s) / 2;
                if (h >= 2+s && ((h - s) % 2) == 0 && k < OBJ_N) cur_do = ref_mem[k];
                if (ovf_k >= 0 && h == 2*ovf_k+2+s) cur_ovf = 1'b1;
            end
            chk($sformatf("rohvs h=%0d", h), ROHVS, (h < abort_h && low_at[h]) ? 0 : 1);
            chk($sformatf("do h=%0d", h), DO, cur_do);
            chk($sformatf("ovf h=%0d", h), obj_ovf, cur_ovf);
            if (!ROHVS) nlow_got++;
            if (s == 2 && h == 0) chk("coll_ack", dma_if.dma_ack, 1);
        end
        chk("line_writes", nlow_got, nlow_exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0]  a;
        logic [28:0] d, keep;
        rst_n = 1'b0; pxl_cen = 1'b0; H = 8'd0; V = 8'd0; LVBL = 1'b0;
        tb_we = 1'b0; tb_a = '0; tb_d = '0;
        dma_if.dma_req = 1'b0; dma_if.dma_we = 1'b0; dma_if.dma_addr = '0; dma_if.dma_din = '0;
        cur_do = '0; cur_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_obj_addr", obj_addr, 0);
        chk("rst_obj_we", obj_we, 0);
        chk("rst_obj_din", obj_din, 0);
        chk("rst_do", DO, 0);
        chk("rst_rohvs", ROHVS, 1);
        chk("rst_dma_ack", dma_if.dma_ack, 0);
        chk("rst_dma_dout", dma_if.dma_dout, 0);
        chk("rst_ovf", obj_ovf, 0);
        @(negedge clk) rst_n = 1'b1;

        // Single in-zone object at entry 5
        V = 8'h10;
        for (int j = 0; j < 128; j++) begin
            ref_mem[j] = 29'($urandom);
            ref_mem[j][15:8] = (j == 5) ? 8'hF3 : 8'h00;
        end
        load_mem();
        run_line(0, 256);

        // Zone edges and wraparound
        V = 8'h08;
        for (int j = 0; j < 128; j++) begin
            ref_mem[j] = 29'($urandom);
            ref_mem[j][15:8] = 8'h20;
        end
        ref_mem[3][15:8]  = 8'hF8;
        ref_mem[7][15:8]  = 8'hF0;
        ref_mem[10][15:8] = 8'hFF;
        load_mem();
        run_line(0, 256);

        // Budget overflow, then a random line that must clear the flag
        V = 8'($urandom);
        fill_rand(100);
        load_mem();
        run_line(0, 256);
        for (int n = 0; n < 3; n++) begin
            V = 8'($urandom);
            fill_rand(int'($urandom_range(100, 0)));
            load_mem();
            run_line(0, 256);
        end

        // DMA during vblank
        LVBL = 1'b0; H = 8'hE1;
        dma_xfer(1'b1, 7'h40, 29'h1ABCDEF0);
        dma_xfer(1'b0, 7'h40, 29'h0);
        for (int n = 0; n < 4; n++) begin
            a = 7'($urandom);
            d = 29'($urandom);
            dma_xfer(1'($urandom), a, d);
        end

        // DMA request taken at H=0xFF delays the scan by 2
        V = 8'($urandom);
        fill_rand(50);
        load_mem();
        a = 7'($urandom);
        LVBL = 1'b1; H = 8'hFF;
        dma_if.dma_req = 1'b1; dma_if.dma_we = 1'b0; dma_if.dma_addr = a;
        step();
        chk("coll_issue_addr", obj_addr, a);
        chk("coll_issue_ack", dma_if.dma_ack, 0);
        run_line(2, 256);
        chk("coll_dout", dma_if.dma_dout, ref_mem[a]);

        // LVBL falls mid-scan with in-zone objects still pending
        V = 8'($urandom);
        fill_rand(100);
        load_mem();
        run_line(0, 8'h40);
        dma_xfer(1'b0, 7'($urandom), 29'h0);

        // Reset while a DMA write is in flight: no ack, no write
        keep = ref_mem[7'h11];
        LVBL = 1'b0; H = 8'h80;
        dma_if.dma_req = 1'b1; dma_if.dma_we = 1'b1; dma_if.dma_addr = 7'h11;
        dma_if.dma_din = ~keep;
        step();
        chk("rst_dma_issue_we", obj_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_obj_we", obj_we, 0);
        chk("rstmid_obj_addr", obj_addr, 0);
        chk("rstmid_rohvs", ROHVS, 1);
        chk("rstmid_do", DO, 0);
        chk("rstmid_ack", dma_if.dma_ack, 0);
        dma_if.dma_req = 1'b0;
        cur_do = '0; cur_ovf = 1'b0;
        step();
        chk("rstheld_ack", dma_if.dma_ack, 0);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk($sformatf("rstpost_ack%0d", n), dma_if.dma_ack, 0);
        end
        dma_xfer(1'b0, 7'h11, 29'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
